// File: rtl/stepper_phase_decoder.sv
// Observes a stepper coil drive pattern, debounces it, decodes half-step phases
// and tracks a signed half-step position with direction and error pulses.
module stepper_phase_decoder #(
   parameter int STABLE_CYCLES = 4,
   parameter int POS_WIDTH     = 16
) (
   input  logic                 system1000,
   input  logic                 system1000_rst,
   input  logic [3:0]           coils,
   input  logic                 clear,
   output logic [POS_WIDTH-1:0] position,
   output logic                 step_fwd,
   output logic                 step_rev,
   output logic                 idle,
   output logic                 locked,
   output logic                 err_invalid,
   output logic                 err_skip
);

   typedef enum logic {UNLOCKED, LOCKED} state_t;

   localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

   state_t                      state;
   logic [3:0]                  s1, s2, cand, acc;
   logic [7:0]                  cnt;
   logic [2:0]                  ref_ph;
   logic signed [POS_WIDTH-1:0] pos_q;

   logic                        accept, cand_valid, cand_idle;
   logic                        is_fwd, is_rev, is_skip;
   logic [2:0]                  cand_phase, diff;
   logic signed [3:0]           delta;
   logic signed [POS_WIDTH-1:0] pos_next;

   // Returns {valid, phase index}; 0000 and the seven non-table codes are not valid.
   function automatic logic [3:0] decode_phase(input logic [3:0] pat);
      case (pat)
         4'b1000: decode_phase = 4'b1_000;
         4'b1100: decode_phase = 4'b1_001;
         4'b0100: decode_phase = 4'b1_010;
         4'b0110: decode_phase = 4'b1_011;
         4'b0010: decode_phase = 4'b1_100;
         4'b0011: decode_phase = 4'b1_101;
         4'b0001: decode_phase = 4'b1_110;
         4'b1001: decode_phase = 4'b1_111;
         default: decode_phase = 4'b0_000;
      endcase
   endfunction

   // Position deliberately wraps: no saturation on overflow.
   function automatic logic signed [POS_WIDTH-1:0] wrap_add(
      input logic signed [POS_WIDTH-1:0] base,
      input logic signed [3:0]           inc
   );
      wrap_add = base + POS_WIDTH'(inc);
   endfunction

   always_comb begin
      {cand_valid, cand_phase} = decode_phase(cand);
      cand_idle = (cand == 4'b0000);
      accept    = (cnt == STABLE_CNT) && (cand != acc);
      diff      = cand_phase - ref_ph;
      is_fwd    = 1'b0;
      is_rev    = 1'b0;
      is_skip   = 1'b0;
      delta     = 4'sd0;
      if (accept && cand_valid && state == LOCKED) begin
         case (diff)
            3'd1:             begin is_fwd = 1'b1; delta = 4'sd1;  end
            3'd2:             begin is_fwd = 1'b1; delta = 4'sd2;  end
            3'd7:             begin is_rev = 1'b1; delta = -4'sd1; end
            3'd6:             begin is_rev = 1'b1; delta = -4'sd2; end
            3'd3, 3'd4, 3'd5: is_skip = 1'b1;
            default:          ;
         endcase
      end
      pos_next = wrap_add(pos_q, delta);
   end

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         s1          <= 4'b0000;
         s2          <= 4'b0000;
         cand        <= 4'b0000;
         cnt         <= 8'd0;
         acc         <= 4'b0000;
         ref_ph      <= 3'd0;
         state       <= UNLOCKED;
         pos_q       <= '0;
         step_fwd    <= 1'b0;
         step_rev    <= 1'b0;
         err_invalid <= 1'b0;
         err_skip    <= 1'b0;
         locked      <= 1'b0;
         idle        <= 1'b1;
      end else begin
         s1 <= coils;
         s2 <= s1;
         // Restart the stability count whenever the synchronised pattern moves.
         if (s2 != cand) begin
            cand <= s2;
            cnt  <= 8'd1;
         end else if (cnt != STABLE_CNT) begin
            cnt <= cnt + 8'd1;
         end

         step_fwd    <= is_fwd;
         step_rev    <= is_rev;
         err_skip    <= is_skip;
         err_invalid <= 1'b0;
         pos_q       <= clear ? '0 : pos_next;

         if (accept) begin
            acc  <= cand;
            idle <= cand_idle;
            if (cand_valid) begin
               ref_ph <= cand_phase;
               state  <= LOCKED;
               locked <= 1'b1;
            end else if (!cand_idle) begin
               err_invalid <= 1'b1;
               state       <= UNLOCKED;
               locked      <= 1'b0;
            end
         end
      end
   end

   assign position = pos_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Directed and randomized checks of stepper_phase_decoder against a phase-table
// reference model that works at the level of whole accepted patterns.
module tb_stepper_phase_decoder;

   localparam int S    = 4;
   localparam int PW   = 8;
   localparam int MASK = (1 << PW) - 1;
   localparam int LAT  = S + 3;

   localparam int EV_NONE = 0;
   localparam int EV_FWD  = 1;
   localparam int EV_REV  = 2;
   localparam int EV_INV  = 3;
   localparam int EV_SKIP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    coils;
   logic          clear;
   logic [PW-1:0] position;
   logic          step_fwd, step_rev, idle, locked, err_invalid, err_skip;

   logic [3:0] PH [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                          4'b0010, 4'b0011, 4'b0001, 4'b1001};

   int         checks, errors;
   int         m_pos, m_ref;
   logic       m_locked, m_idle;
   logic [3:0] m_acc, last_drv;

   stepper_phase_decoder #(.STABLE_CYCLES(S), .POS_WIDTH(PW)) dut (
      .system1000     (clk),
      .system1000_rst (rst),
      .coils          (coils),
      .clear          (clear),
      .position       (position),
      .step_fwd       (step_fwd),
      .step_rev       (step_rev),
      .idle           (idle),
      .locked         (locked),
      .err_invalid    (err_invalid),
      .err_skip       (err_skip)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int phase_of(input logic [3:0] p);
      for (int i = 0; i < 8; i++)
         if (PH[i] == p) return i;
      return -1;
   endfunction

   task automatic model_reset();
      m_pos    = 0;
      m_ref    = 0;
      m_locked = 1'b0;
      m_idle   = 1'b1;
      m_acc    = 4'b0000;
   endtask

   // Predicts the effect of holding pat for hold cycles, with clear raised at clr_tick (0 = never).
   task automatic model_window(input logic [3:0] pat, input int hold, input int clr_tick,
                               output int ev, output bit accd);
      int idx, d, delta;
      ev    = EV_NONE;
      delta = 0;
      accd  = (hold >= S) && (pat != m_acc);
      if (accd) begin
         idx    = phase_of(pat);
         m_acc  = pat;
         m_idle = (pat == 4'b0000);
         if (idx >= 0) begin
            if (m_locked) begin
               d = (idx - m_ref + 8) % 8;
               if (d == 1 || d == 2) begin
                  ev = EV_FWD; delta = d;
               end else if (d == 6 || d == 7) begin
                  ev = EV_REV; delta = d - 8;
               end else if (d >= 3 && d <= 5) begin
                  ev = EV_SKIP;
               end
            end
            m_locked = 1'b1;
            m_ref    = idx;
         end else if (pat != 4'b0000) begin
            ev       = EV_INV;
            m_locked = 1'b0;
         end
      end
      if (clr_tick > 0 && clr_tick < LAT) m_pos = 0;
      m_pos = (m_pos + delta) & MASK;
      if (clr_tick >= LAT) m_pos = 0;
   endtask

   task automatic window(input logic [3:0] pat, input int hold, input int clr_tick, input string tag);
      int   cf, cr, ci, cs, ev_tick, ev, exp_tick, obs_w, exp_w;
      bit   accd;
      logic pl, pi;
      model_window(pat, hold, clr_tick, ev, accd);
      cf = 0; cr = 0; ci = 0; cs = 0; ev_tick = 0;
      pl = locked;
      pi = idle;
      coils    = pat;
      last_drv = pat;
      for (int t = 1; t <= hold; t++) begin
         clear = (t == clr_tick);
         tick();
         clear = 1'b0;
         check({tag, "/onehot"},
               32'($countones({step_fwd, step_rev, err_invalid, err_skip}) <= 1), 32'd1);
         cf += int'(step_fwd);
         cr += int'(step_rev);
         ci += int'(err_invalid);
         cs += int'(err_skip);
         if (ev_tick == 0 && (step_fwd || step_rev || err_invalid || err_skip ||
                              locked != pl || idle != pi))
            ev_tick = t;
      end
      exp_tick = accd ? LAT : 0;
      obs_w = cf * 4096 + cr * 256 + ci * 16 + cs;
      exp_w = (ev == EV_FWD ? 4096 : 0) + (ev == EV_REV ? 256 : 0) +
              (ev == EV_INV ? 16 : 0) + (ev == EV_SKIP ? 1 : 0);
      check({tag, "/pulses"},   32'(obs_w),   32'(exp_w));
      check({tag, "/latency"},  32'(ev_tick), 32'(exp_tick));
      check({tag, "/position"}, 32'(position), 32'(m_pos));
      check({tag, "/locked"},   32'(locked),   32'(m_locked));
      check({tag, "/idle"},     32'(idle),     32'(m_idle));
   endtask

   initial begin
      logic [3:0] pat;
      int         hold, clr;
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      coils    = 4'b0000;
      clear    = 1'b0;
      last_drv = 4'b0000;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      check("rst/position", 32'(position), 32'd0);
      check("rst/locked",   32'(locked),   32'd0);
      check("rst/idle",     32'(idle),     32'd1);
      check("rst/pulses",   32'({step_fwd, step_rev, err_invalid, err_skip}), 32'd0);

      window(4'b1000, 10, 0, "lock");
      check("lock/pos0", 32'(position), 32'd0);

      for (int i = 1; i <= 8; i++) window(PH[i % 8], 8, 0, "half_fwd");
      check("half_fwd/pos8", 32'(position), 32'd8);
      for (int i = 7; i >= 0; i--) window(PH[i], 8, 0, "half_rev");
      check("half_rev/pos0", 32'(position), 32'd0);

      window(4'b1100, 8, LAT + 1, "full_start");
      window(4'b0110, 8, 0, "full");
      window(4'b0011, 8, 0, "full");
      window(4'b1001, 8, 0, "full");
      window(4'b1100, 8, 0, "full");
      check("full/pos8", 32'(position), 32'd8);

      window(PH[(m_ref + 1) % 8], LAT, LAT, "wrap_clr");
      for (int i = 0; i < 127; i++) window(PH[(m_ref + 1) % 8], LAT, 0, "wrap_up");
      check("wrap/7f", 32'(position), 32'h7F);
      window(PH[(m_ref + 1) % 8], LAT, 0, "wrap_over");
      check("wrap/80", 32'(position), 32'h80);
      window(PH[(m_ref + 7) % 8], LAT, 0, "wrap_back");
      window(PH[(m_ref + 7) % 8], LAT, 1, "wrap_neg");
      check("wrap/ff", 32'(position), 32'hFF);

      window(4'b1000, 8, 0, "skip_pre");
      window(4'b0010, 8, 0, "skip");
      window(4'b0011, 8, 0, "skip_after");

      window(4'b1010, 8, 0, "invalid");
      check("invalid/unlocked", 32'(locked), 32'd0);
      window(4'b0100, 8, 0, "relock");

      window(4'b1100, 8, 0, "glitch_base");
      window(4'b0100, 2, 0, "glitch");
      window(4'b1100, 8, 0, "glitch_back");

      window(4'b0100, 8, LAT, "clear_coincide");
      check("clear_coincide/pos0", 32'(position), 32'd0);

      coils    = 4'b0110;
      last_drv = 4'b0110;
      repeat (3) tick();
      #1 rst = 1'b1;
      #1;
      check("rst_debounce/position", 32'(position), 32'd0);
      check("rst_debounce/locked",   32'(locked),   32'd0);
      check("rst_debounce/idle",     32'(idle),     32'd1);
      #1 rst = 1'b0;
      model_reset();
      window(4'b0110, 8, 0, "post_rst");

      coils    = 4'b0010;
      last_drv = 4'b0010;
      repeat (LAT) tick();
      check("rst_pulse/pre", 32'(step_fwd), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("rst_pulse/fwd",    32'(step_fwd), 32'd0);
      check("rst_pulse/locked", 32'(locked),   32'd0);
      #1 rst = 1'b0;
      model_reset();
      window(4'b0010, 8, 0, "post_rst_pulse");

      for (int n = 0; n < 80; n++) begin
         do begin
            if ($urandom_range(0, 1) == 0) pat = PH[(m_ref + $urandom_range(1, 7)) % 8];
            else                           pat = 4'($urandom_range(0, 15));
         end while (pat == last_drv);
         if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, S - 1);
         else                           hold = $urandom_range(LAT, LAT + 3);
         clr = ($urandom_range(0, 9) == 0) ? $urandom_range(1, hold) : 0;
         window(pat, hold, clr, "random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
